// File: rtl/aes_pkg.sv
// Shared AES-128 decryption definitions: round count, FSM encoding and the inverse S-box.
package aes_pkg;

  localparam int unsigned NR    = 10;
  localparam int unsigned RND_W = 4;
  localparam int unsigned BLK_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    APPLY = 2'd2,
    DONE  = 2'd3
  } aes_state_e;

  // Inverse S-box; element 0 sits in the most significant byte.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse cipher round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] state,
  input  logic [BLK_W-1:0] key,
  input  logic             last,
  output logic [BLK_W-1:0] next
);

  logic [BLK_W-1:0] ark;
  logic [BLK_W-1:0] mix;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  // Byte n lives at bits [127-8n -: 8]; n = row + 4*column.
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;

    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int unsigned SRC = 4 * ((c + 4 - r) % 4) + r;
      localparam int unsigned DST = 4 * c + r;
      assign ark[BLK_W-1-8*DST -: 8] =
        inv_sbox(state[BLK_W-1-8*SRC -: 8]) ^ key[BLK_W-1-8*DST -: 8];
    end

    assign a0 = ark[BLK_W-1-8*(4*c+0) -: 8];
    assign a1 = ark[BLK_W-1-8*(4*c+1) -: 8];
    assign a2 = ark[BLK_W-1-8*(4*c+2) -: 8];
    assign a3 = ark[BLK_W-1-8*(4*c+3) -: 8];

    assign mix[BLK_W-1-8*(4*c+0) -: 8] = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
    assign mix[BLK_W-1-8*(4*c+1) -: 8] = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
    assign mix[BLK_W-1-8*(4*c+2) -: 8] = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
    assign mix[BLK_W-1-8*(4*c+3) -: 8] = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
  end

  assign next = last ? ark : mix;

endmodule

// File: rtl/aes_decryption.sv
// Iterative AES-128 decryption: one round per REQ/APPLY pair, round keys fetched
// from an external scheduler in order 10 down to 0.
module aes_decryption
  import aes_pkg::*;
#(
  parameter int unsigned BLOCK_LENGTH = 128
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    En,
  input  logic [BLOCK_LENGTH-1:0] CT,
  input  logic [BLOCK_LENGTH-1:0] K_i,
  output logic                    K_Req,
  output logic [RND_W-1:0]        K_Idx,
  output logic [BLOCK_LENGTH-1:0] PT,
  output logic                    Valid,
  output logic                    Busy
);

  aes_state_e              fsm_q, fsm_d;
  logic [RND_W-1:0]        rnd_q, rnd_d;
  logic [BLOCK_LENGTH-1:0] blk_q, blk_d;
  logic [BLOCK_LENGTH-1:0] pt_d;
  logic [BLOCK_LENGTH-1:0] round_out;
  logic [RND_W-1:0]        kidx_d;
  logic                    kreq_d, valid_d, busy_d, last_round;

  assign last_round = (rnd_q == '0);

  aes_inv_round u_round (
    .state (blk_q),
    .key   (K_i),
    .last  (last_round),
    .next  (round_out)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fsm_q <= IDLE;
      rnd_q <= '0;
      blk_q <= '0;
      PT    <= '0;
      Valid <= 1'b0;
      Busy  <= 1'b0;
      K_Req <= 1'b0;
      K_Idx <= '0;
    end else begin
      fsm_q <= fsm_d;
      rnd_q <= rnd_d;
      blk_q <= blk_d;
      PT    <= pt_d;
      Valid <= valid_d;
      Busy  <= busy_d;
      K_Req <= kreq_d;
      K_Idx <= kidx_d;
    end
  end

  // Outputs are registered from the next-state values so they line up with the state.
  always_comb begin
    fsm_d = fsm_q;
    rnd_d = rnd_q;
    blk_d = blk_q;
    pt_d  = PT;

    case (fsm_q)
      IDLE: begin
        if (En) begin
          blk_d = CT;
          rnd_d = RND_W'(NR);
          fsm_d = REQ;
        end
      end
      REQ: fsm_d = APPLY;
      APPLY: begin
        if (rnd_q == RND_W'(NR)) begin
          blk_d = blk_q ^ K_i;
        end else if (!last_round) begin
          blk_d = round_out;
        end
        if (last_round) begin
          pt_d  = round_out;
          fsm_d = DONE;
        end else begin
          rnd_d = rnd_q - RND_W'(1);
          fsm_d = REQ;
        end
      end
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase

    kreq_d  = (fsm_d == REQ);
    kidx_d  = (fsm_d == REQ) ? rnd_d : K_Idx;
    valid_d = (fsm_d == DONE);
    busy_d  = (fsm_d != IDLE);
  end

endmodule
